oled_spi_sink: RTL and testbench
================================

Name: oled_spi_sink

Overview:
- Display-side end of the 4-wire SPI link driven by the OLED driver (sclk, sdin, cs, dc, reset).
- Oversamples the serial lines on `clk` and assembles bytes.
- Decodes the SSD1306 command subset the driver emits, and turns data bytes into framebuffer writes at an auto-incrementing, horizontally addressed location.
- Used as an in-fabric display model for simulation, and to mirror the 128x64 framebuffer into on-chip RAM for other consumers.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each SPI input before edge detection (minimum 2).
- COLS, 128: display columns; column pointer width is 7 bits.
- PAGES, 8: 8-pixel-high pages; page pointer width is 3 bits.

Ports:
- clk  input  1  system clock; must be at least 4x the sclk frequency.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from the driver; idle low; sdin sampled on its rising edge.
- sdin  input  1  SPI data, MSB first.
- cs  input  1  chip select, active low.
- dc  input  1  0 = command byte, 1 = data byte; sampled with bit 0 of the byte.
- resN  input  1  display reset from the driver, active low.
- fbWe  output  1  framebuffer write strobe, one clk cycle.
- fbAddr  output  10  write address = page*128 + col.
- fbData  output  8  data byte; bit 0 is the top pixel of the page column.
- cmdValid  output  1  one-cycle pulse per received command byte.
- cmdByte  output  8  last command byte; valid with cmdValid.
- displayOn  output  1  1 after 0xAF, 0 after 0xAE.
- frameDone  output  1  one-cycle pulse when the page pointer wraps past pageEnd.

Behaviour:
- Reset values (reset=1, or synchronised resN=0):
  - All outputs 0.
  - Column window 0..127, page window 0..7; col=0, page=0.
  - Bit counter 0; parser in CMD.
  - resN is synchronised through the same stages as the SPI lines.
- Byte assembly:
  - Each synchronised sclk rising edge with synchronised cs=0 shifts sdin into an 8-bit register, MSB first.
  - On the 8th edge, the byte and the dc value are latched.
- cs high:
  - Clears the bit counter immediately; a partial byte is discarded with no strobe.
  - Parser state and pointers are retained.
- Latency: fbWe or cmdValid asserts exactly SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pins.
- Data byte (dc=1):
  - fbWe=1 with fbAddr = {page, col} and fbData = byte.
  - Next cycle: if col==colEnd, col←colStart and the page advances; otherwise col←col+1 (mod 128).
  - Page advance: if page==pageEnd, page←pageStart and frameDone pulses in the same cycle as the pointer update; otherwise page←page+1 (mod 8).
  - Data bytes never change parser state.
- Command byte (dc=0): cmdValid=1 and cmdByte updated.
- Parser FSM, states CMD, COL_S, COL_E, PG_S, PG_E, SKIP1:
  - CMD:
    - 0x21→COL_S; 0x22→PG_S.
    - 0xAE→displayOn=0; 0xAF→displayOn=1.
    - Any of {0x20,0x81,0x8D,0xA8,0xD3,0xD5,0xD9,0xDA,0xDB}→SKIP1.
    - Any other byte is ignored, stay in CMD.
  - COL_S: colStart←byte[6:0], →COL_E.
  - COL_E: colEnd←byte[6:0], col←colStart, →CMD.
  - PG_S: pageStart←byte[2:0], →PG_E.
  - PG_E: pageEnd←byte[2:0], page←pageStart, →CMD.
  - SKIP1: consume one argument byte, →CMD.
  - Argument bytes still pulse cmdValid.
- start > end: pointers still increment modulo 128 or 8 until equal to end, then reload start. No error is flagged.
- Simultaneous reset and a completing byte: reset wins; no strobe.

Decomposition:
- Shared package oled_pkg:
  - Opcode constants CMD_SET_COL=0x21, CMD_SET_PAGE=0x22, CMD_DISP_OFF=0xAE, CMD_DISP_ON=0xAF.
  - The single-argument opcode list.
  - FB_ADDR_W=10.
  - Parser state enum.
- One sub-module spi_byte_rx holds the synchronisers, sclk edge detect, bit counter and shift register. It outputs a byteValid pulse with byte[7:0] and isData. The parent holds the parser, the pointers and the outputs.

Test Plan:
- Reset then 0xAF (dc=0), sclk = clk/8 → cmdValid one pulse with cmdByte=0xAF; displayOn=1; pulse is SYNC_STAGES+2 cycles after the 8th sclk rise.
- 1024 data bytes 0x00..0xFF repeating → fbWe at addresses 0..1023 in order, each fbData matching the sent byte; frameDone exactly once, together with the pointer update after address 1023.
- Set column window 10..12 and page window 3..4 (0x21,0x0A,0x0C,0x22,0x03,0x04), then 7 data bytes → addresses 394,395,396,522,523,524,394; frameDone after the 6th byte.
- Send 0x81,0xAF then 0xAE → 0xAF is consumed as the contrast argument so displayOn stays 0; 0xAE parsed; three cmdValid pulses.
- 5 bits of 0xFF, cs high for 4 clk, then full byte 0x5A with dc=1 → one fbWe only, fbData=0x5A at address 0.
- resN low for 10 clk in mid-frame (col=37, page=2) → pointers return to 0, window to default, displayOn=0, no fbWe while resN is low.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI sink.
// Contents: opcode constants of the SSD1306 command subset, the opcodes that
// take exactly one argument byte, framebuffer address width and the command
// parser state type.
package oled_pkg;

  localparam int FB_ADDR_W = 10;

  localparam logic [7:0] CMD_SET_COL  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_COL_S,
    ST_COL_E,
    ST_PG_S,
    ST_PG_E,
    ST_SKIP1
  } parse_state_e;

  // Opcodes followed by one argument byte that this model does not interpret.
  function automatic logic is_one_arg(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: is_one_arg = 1'b1;
      default:                    is_one_arg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// 4-wire SPI link plus display reset between OLED driver and display.
//   sclk : SPI clock, idle low, data sampled on rising edge
//   sdin : serial data, MSB first
//   cs   : chip select, active low
//   dc   : 0 = command byte, 1 = data byte
//   resN : display reset, active low
// master = driver side, slave = display side.
interface oled_spi_sink_if;
  logic sclk;
  logic sdin;
  logic cs;
  logic dc;
  logic resN;

  modport master (output sclk, sdin, cs, dc, resN);
  modport slave  (input  sclk, sdin, cs, dc, resN);
endinterface

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver.
//   clk, reset   : system clock, synchronous active-high reset
//   spi          : SPI link (slave modport), asynchronous to clk
//   byte_valid_o : one-cycle pulse when 8 bits have been received
//   byte_o       : received byte, valid with byte_valid_o
//   is_data_o    : dc level captured with the last bit
//   res_n_o      : synchronised resN
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  oled_spi_sink_if.slave        spi,
  output logic                  byte_valid_o,
  output logic [7:0]            byte_o,
  output logic                  is_data_o,
  output logic                  res_n_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdin_sync_q, cs_sync_q, dc_sync_q, resn_sync_q;
  logic                   sclk_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic                   byte_valid_q;
  logic [7:0]             byte_q;
  logic                   is_data_q;

  logic sclk_s, sdin_s, cs_s, dc_s, resn_s, sclk_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign resn_s    = resn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // All lines share the same depth so sdin/dc/cs stay aligned with sclk.
  // Only the hard reset clears the synchronisers; resN must keep flowing
  // through them or a low resN could never be released.
  // NOTE: synchronous reset -- the reset test sits inside the clocked block
  // and is only seen on a rising clk edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      sdin_sync_q <= '0;
      cs_sync_q   <= '1;
      dc_sync_q   <= '0;
      resn_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], spi.sdin};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi.cs};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   spi.dc};
      resn_sync_q <= {resn_sync_q[SYNC_STAGES-2:0], spi.resN};
      sclk_prev_q <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !resn_s) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      is_data_q    <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (cs_s) begin
        // Deselect drops any partial byte.
        bit_cnt_q <= '0;
      end else if (sclk_rise) begin
        shift_q   <= {shift_q[5:0], sdin_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          byte_q       <= {shift_q, sdin_s};
          is_data_q    <= dc_s;
        end
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign is_data_o    = is_data_q;
  assign res_n_o      = resn_s;

endmodule

// File: rtl/oled_spi_sink.sv
// Display-side model of an SSD1306-style OLED on a 4-wire SPI link.
// Receives bytes, parses the command subset (column/page windows, display
// on/off, single-argument opcodes skipped) and turns data bytes into
// framebuffer writes with horizontal auto-increment.
//   clk, reset : system clock (>= 4x sclk), synchronous active-high reset
//   spi        : SPI link from the driver (slave modport)
//   fbWe/fbAddr/fbData : one-cycle framebuffer write, addr = page*128 + col
//   cmdValid/cmdByte   : one-cycle pulse per command byte
//   displayOn  : display on/off state
//   frameDone  : pulse when the page pointer wraps past the page window end
module oled_spi_sink
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  oled_spi_sink_if.slave       spi,
  output logic                 fbWe,
  output logic [FB_ADDR_W-1:0] fbAddr,
  output logic [7:0]           fbData,
  output logic                 cmdValid,
  output logic [7:0]           cmdByte,
  output logic                 displayOn,
  output logic                 frameDone
);

  localparam int COL_W = $clog2(COLS);
  localparam int PG_W  = $clog2(PAGES);

  logic       rx_valid, rx_is_data, res_n_sync, soft_rst;
  logic [7:0] rx_byte;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .spi          (spi),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .is_data_o    (rx_is_data),
    .res_n_o      (res_n_sync)
  );

  assign soft_rst = reset | ~res_n_sync;

  parse_state_e         state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PG_W-1:0]      page_q, page_d, pg_start_q, pg_start_d, pg_end_q, pg_end_d;
  logic                 fb_we_q, fb_we_d, cmd_valid_q, cmd_valid_d;
  logic                 disp_on_q, disp_on_d, frame_done_q, frame_done_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]           fb_data_q, fb_data_d, cmd_byte_q, cmd_byte_d;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    pg_start_d   = pg_start_q;
    pg_end_d     = pg_end_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    disp_on_d    = disp_on_q;
    frame_done_d = 1'b0;

    // Pointers move the cycle after a write strobe. Comparisons are for
    // equality only, so a window with start > end wraps through 0.
    if (fb_we_q) begin
      if (col_q == col_end_q) begin
        col_d = col_start_q;
        if (page_q == pg_end_q) begin
          page_d       = pg_start_q;
          frame_done_d = 1'b1;
        end else begin
          page_d = page_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (rx_valid) begin
      if (rx_is_data) begin
        fb_we_d   = 1'b1;
        fb_addr_d = {page_q, col_q};
        fb_data_d = rx_byte;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = rx_byte;
        unique case (state_q)
          ST_CMD: begin
            if (rx_byte == CMD_SET_COL)       state_d = ST_COL_S;
            else if (rx_byte == CMD_SET_PAGE) state_d = ST_PG_S;
            else if (rx_byte == CMD_DISP_OFF) disp_on_d = 1'b0;
            else if (rx_byte == CMD_DISP_ON)  disp_on_d = 1'b1;
            else if (is_one_arg(rx_byte))     state_d = ST_SKIP1;
          end
          ST_COL_S: begin
            col_start_d = rx_byte[COL_W-1:0];
            state_d     = ST_COL_E;
          end
          ST_COL_E: begin
            col_end_d = rx_byte[COL_W-1:0];
            col_d     = col_start_q;
            state_d   = ST_CMD;
          end
          ST_PG_S: begin
            pg_start_d = rx_byte[PG_W-1:0];
            state_d    = ST_PG_E;
          end
          ST_PG_E: begin
            pg_end_d = rx_byte[PG_W-1:0];
            page_d   = pg_start_q;
            state_d  = ST_CMD;
          end
          default: state_d = ST_CMD;   // ST_SKIP1: argument consumed
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q      <= ST_CMD;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_W'(COLS - 1);
      pg_start_q   <= '0;
      pg_end_q     <= PG_W'(PAGES - 1);
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= '0;
      disp_on_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      pg_start_q   <= pg_start_d;
      pg_end_q     <= pg_end_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      disp_on_q    <= disp_on_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fbWe      = fb_we_q;
  assign fbAddr    = fb_addr_q;
  assign fbData    = fb_data_q;
  assign cmdValid  = cmd_valid_q;
  assign cmdByte   = cmd_byte_q;
  assign displayOn = disp_on_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Self-checking bench for oled_spi_sink: drives SPI bytes, predicts writes,
// commands and frame pulses with a behavioural display model.
module tb_oled_spi_sink;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       fbWe, cmdValid, displayOn, frameDone;
  logic [9:0] fbAddr;
  logic [7:0] fbData, cmdByte;

  oled_spi_sink_if spi_if ();

  oled_spi_sink #(.SYNC_STAGES(SYNC_STAGES), .COLS(128), .PAGES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi       (spi_if),
    .fbWe      (fbWe),
    .fbAddr    (fbAddr),
    .fbData    (fbData),
    .cmdValid  (cmdValid),
    .cmdByte   (cmdByte),
    .displayOn (displayOn),
    .frameDone (frameDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- observed events ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } obs_wr_t;
  typedef struct { logic [31:0] b; int cyc; } obs_cmd_t;
  obs_wr_t  obs_wr[$];
  obs_cmd_t obs_cmd[$];
  int       obs_frame[$];

  always @(posedge clk) begin
    #1;
    if (fbWe === 1'b1)      obs_wr.push_back('{addr: 32'(fbAddr), data: 32'(fbData), cyc: cyc});
    if (cmdValid === 1'b1)  obs_cmd.push_back('{b: 32'(cmdByte), cyc: cyc});
    if (frameDone === 1'b1) obs_frame.push_back(cyc);
  end

  // ---------------- reference model ----------------
  typedef struct { int addr; int data; bit frame; } exp_wr_t;
  exp_wr_t exp_wr[$];
  int      exp_cmd[$];
  int      m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_disp, m_op, m_args;

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_disp = 0; m_op = 0; m_args = 0;
  endtask

  task automatic model_byte(input bit dc, input int b);
    if (dc) begin
      exp_wr.push_back('{addr: m_page * 128 + m_col, data: b,
                         frame: (m_col == m_ce) && (m_page == m_pe)});
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
      end else begin
        m_col = (m_col + 1) % 128;
      end
    end else begin
      exp_cmd.push_back(b);
      if (m_args == 0) begin
        if (b == 'h21 || b == 'h22) begin m_op = b; m_args = 2; end
        else if (b == 'hAE) m_disp = 0;
        else if (b == 'hAF) m_disp = 1;
        else if (b inside {'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) begin
          m_op = b; m_args = 1;
        end
      end else begin
        if (m_op == 'h21) begin
          if (m_args == 2) m_cs = b % 128;
          else begin m_ce = b % 128; m_col = m_cs; end
        end else if (m_op == 'h22) begin
          if (m_args == 2) m_ps = b % 8;
          else begin m_pe = b % 8; m_page = m_ps; end
        end
        m_args--;
      end
    end
  endtask

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    int n_fr = 0;
    check({tag, ":wr_count"}, obs_wr.size(), exp_wr.size());
    foreach (exp_wr[i]) if (exp_wr[i].frame) n_fr++;
    check({tag, ":frame_count"}, obs_frame.size(), n_fr);
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      check({tag, ":addr"}, obs_wr[i].addr, exp_wr[i].addr);
      check({tag, ":data"}, obs_wr[i].data, exp_wr[i].data);
      if (exp_wr[i].frame && obs_frame.size() > 0)
        check({tag, ":frame_cycle"}, obs_frame.pop_front(), obs_wr[i].cyc + 1);
    end
    check({tag, ":cmd_count"}, obs_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
      check({tag, ":cmd_byte"}, obs_cmd[i].b, exp_cmd[i]);
    check({tag, ":display_on"}, displayOn, m_disp);
    obs_wr.delete(); obs_cmd.delete(); obs_frame.delete();
    exp_wr.delete(); exp_cmd.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  int rise_cyc;

  task automatic send_bits(input bit dc_v, input logic [7:0] b, input int half, input int nbits);
    spi_if.cs = 1'b0;
    spi_if.dc = dc_v;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_if.sdin = b[i];
      repeat (half) @(negedge clk);
      spi_if.sclk = 1'b1;
      rise_cyc = cyc;
      repeat (half) @(negedge clk);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic tx(input bit dc_v, input logic [7:0] b, input int half);
    send_bits(dc_v, b, half, 8);
    model_byte(dc_v, int'(b));
  endtask

  task automatic cs_high_drain();
    spi_if.cs = 1'b1;
    repeat (SYNC_STAGES + 6) @(negedge clk);
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    obs_wr.delete(); obs_cmd.delete(); obs_frame.delete();
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    reset = 1'b1;
    spi_if.sclk = 1'b0; spi_if.sdin = 1'b0; spi_if.cs = 1'b1;
    spi_if.dc = 1'b0; spi_if.resN = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_fbWe", fbWe, 0);
    check("rst_fbAddr", fbAddr, 0);
    check("rst_fbData", fbData, 0);
    check("rst_cmdValid", cmdValid, 0);
    check("rst_cmdByte", cmdByte, 0);
    check("rst_displayOn", displayOn, 0);
    check("rst_frameDone", frameDone, 0);
    reset = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clk);

    // Display on at sclk = clk/8, with latency measurement
    tx(1'b0, 8'hAF, 4);
    cs_high_drain();
    if (obs_cmd.size() > 0)
      check("cmd_latency", obs_cmd[0].cyc - rise_cyc, SYNC_STAGES + 2);
    compare_all("disp_on");

    // Full frame, 1024 data bytes
    for (int i = 0; i < 1024; i++) tx(1'b1, 8'(i % 256), 2);
    cs_high_drain();
    compare_all("full_frame");

    // Column window 10..12, page window 3..4
    tx(1'b0, 8'h21, 2); tx(1'b0, 8'h0A, 2); tx(1'b0, 8'h0C, 2);
    tx(1'b0, 8'h22, 2); tx(1'b0, 8'h03, 2); tx(1'b0, 8'h04, 2);
    for (int i = 0; i < 7; i++) tx(1'b1, 8'($urandom), 2);
    cs_high_drain();
    if (obs_wr.size() == 7) begin
      check("win_addr0", obs_wr[0].addr, 394);
      check("win_addr3", obs_wr[3].addr, 522);
      check("win_addr6", obs_wr[6].addr, 394);
    end
    compare_all("window");

    // Contrast argument swallows 0xAF
    tx(1'b0, 8'hAE, 2);
    tx(1'b0, 8'h81, 2); tx(1'b0, 8'hAF, 2);
    cs_high_drain();
    compare_all("skip_arg");
    tx(1'b0, 8'hAE, 2);
    cs_high_drain();
    compare_all("disp_off");

    // Partial byte discarded by cs high
    hard_reset();
    send_bits(1'b0, 8'hFF, 2, 5);
    spi_if.cs = 1'b1;
    repeat (4) @(negedge clk);
    tx(1'b1, 8'h5A, 2);
    cs_high_drain();
    compare_all("partial");

    // resN in mid-frame with a non-default window
    tx(1'b0, 8'hAF, 2);
    tx(1'b0, 8'h21, 2); tx(1'b0, 8'd37, 2); tx(1'b0, 8'd127, 2);
    tx(1'b0, 8'h22, 2); tx(1'b0, 8'd2, 2);  tx(1'b0, 8'd7, 2);
    tx(1'b1, 8'($urandom), 2);
    cs_high_drain();
    compare_all("pre_resn");
    spi_if.resN = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    check("resn_no_we", obs_wr.size(), exp_wr.size());
    check("resn_displayOn", displayOn, m_disp);
    check("resn_fbAddr", fbAddr, 0);
    check("resn_cmdByte", cmdByte, 0);
    spi_if.resN = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    for (int i = 0; i < 129; i++) tx(1'b1, 8'($urandom), 2);
    cs_high_drain();
    compare_all("post_resn");

    // Randomized windows, commands and data
    for (int r = 0; r < 4; r++) begin
      int cs_v, ce_v, ps_v, pe_v, k;
      if (r == 0) begin
        cs_v = $urandom_range(100, 127); ce_v = $urandom_range(0, 20);
        ps_v = $urandom_range(6, 7);     pe_v = $urandom_range(0, 1);
      end else begin
        cs_v = $urandom_range(0, 127); ce_v = $urandom_range(0, 127);
        ps_v = $urandom_range(0, 7);   pe_v = $urandom_range(0, 7);
      end
      tx(1'b0, 8'h21, 2); tx(1'b0, 8'(cs_v), 2); tx(1'b0, 8'(ce_v), 2);
      tx(1'b0, 8'h22, 2); tx(1'b0, 8'(ps_v), 2); tx(1'b0, 8'(pe_v), 2);
      k = $urandom_range(0, 3);
      case (k)
        0: tx(1'b0, 8'hAE, 2);
        1: tx(1'b0, 8'hAF, 2);
        2: begin tx(1'b0, 8'h81, 2); tx(1'b0, 8'($urandom), 2); end
        default: tx(1'b0, 8'($urandom_range(0, 255)), 2);
      endcase
      for (int i = 0; i < int'($urandom_range(4, 40)); i++) tx(1'b1, 8'($urandom), 2);
      cs_high_drain();
      compare_all($sformatf("random%0d", r));
      // Resync parser in case a random opcode left it expecting arguments.
      hard_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
